// File: rtl/seg_arbiter_pkg.sv
// Shared constants for the seg_arbiter slice: FSM encodings, the "no owner" grant code,
// the latched message record and small sizing/priority helpers.
package seg_arbiter_pkg;

  localparam int NUM_REQ = 3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SHOW = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  localparam logic [1:0] GRANT_NONE = 2'd3;

  typedef struct packed {
    logic [31:0] value;
    logic [7:0]  en;
    logic        blink;
  } msg_t;

  // Bits needed to hold 0..max_count; never narrower than one bit.
  function automatic int cnt_width(input int max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

  // Lowest-index asserted requester wins; GRANT_NONE when nobody asks.
  function automatic logic [1:0] first_req(input logic [NUM_REQ-1:0] valid);
    logic [1:0] idx;
    idx = GRANT_NONE;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (valid[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/seg_arbiter_if.sv
// Requester/base/display bundle between the message sources and seg_arbiter.
interface seg_arbiter_if
  import seg_arbiter_pkg::*;
();

  logic [31:0]          base_value;
  logic [7:0]           base_en;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*32-1:0] req_value;
  logic [NUM_REQ*8-1:0] req_en;
  logic [NUM_REQ-1:0]   req_blink;
  logic [NUM_REQ-1:0]   req_ready;
  logic [31:0]          seg_value;
  logic [7:0]           seg_en;
  logic [1:0]           grant;
  logic                 busy;

  modport master (
    output base_value, base_en, req_valid, req_value, req_en, req_blink,
    input  req_ready, seg_value, seg_en, grant, busy
  );

  modport slave (
    input  base_value, base_en, req_valid, req_value, req_en, req_blink,
    output req_ready, seg_value, seg_en, grant, busy
  );

endinterface

// File: rtl/seg_hold_timer.sv
// Message hold timer plus blink phase generator; both restart on load.
module seg_hold_timer
  import seg_arbiter_pkg::*;
#(
  parameter int HOLD_CYCLES  = 50_000_000,
  parameter int BLINK_CYCLES = 12_500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic count,
  output logic expire,
  output logic phase    // blink phase for the cycle after this one
);

  localparam int HOLD_W  = cnt_width(HOLD_CYCLES);
  localparam int BLINK_W = cnt_width(BLINK_CYCLES);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);

  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               phase_q, phase_d;
  logic               hold_last, blink_last;

  assign hold_last  = (hold_cnt_q == HOLD_LAST);
  assign blink_last = (blink_cnt_q == BLINK_LAST);
  assign expire     = count & hold_last;
  assign phase      = phase_d;

  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    hold_cnt_d  = hold_cnt_q;
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (load) begin
      hold_cnt_d  = '0;
      blink_cnt_d = '0;
      phase_d     = 1'b1;
    end else if (count) begin
      // The hold count parks on its terminal value instead of wrapping.
      if (!hold_last) hold_cnt_d = hold_cnt_q + 1'b1;
      if (blink_last) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  // NOTE: state flops use non-blocking assignments so all of them sample pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_q  <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
    end else begin
      hold_cnt_q  <= hold_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

endmodule

// File: rtl/seg_arbiter.sv
// Three-source message arbiter for the 7-segment display: base content when idle, a
// granted message for a fixed hold time (optionally blinking), then a short blank gap.
module seg_arbiter
  import seg_arbiter_pkg::*;
#(
  parameter int HOLD_CYCLES  = 50_000_000,
  parameter int BLINK_CYCLES = 12_500_000,
  parameter int GAP_CYCLES   = 2
) (
  input logic          clk,
  input logic          rst_n,
  seg_arbiter_if.slave bus
);

  localparam bit HAS_GAP = (GAP_CYCLES > 0);
  localparam int GAP_W   = cnt_width(GAP_CYCLES);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(HAS_GAP ? GAP_CYCLES - 1 : 0);

  logic [1:0]       state_q, state_d;
  msg_t             msg_q, msg_d;
  logic [1:0]       owner_q, owner_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [31:0]      seg_value_q, seg_value_d;
  logic [7:0]       seg_en_q, seg_en_d;
  logic [1:0]       grant_q, grant_d;
  logic             busy_q, busy_d;

  logic [NUM_REQ-1:0]       ready;
  logic [NUM_REQ-1:0][31:0] req_value_arr;
  logic [NUM_REQ-1:0][7:0]  req_en_arr;
  logic [1:0]               pick;
  logic                     any_req, take, load, count, expire, phase;

  assign req_value_arr = bus.req_value;
  assign req_en_arr    = bus.req_en;
  assign pick          = first_req(bus.req_valid);
  assign any_req       = (pick != GRANT_NONE);
  assign count         = (state_q == ST_SHOW);

  seg_hold_timer #(
    .HOLD_CYCLES  (HOLD_CYCLES),
    .BLINK_CYCLES (BLINK_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .count  (count),
    .expire (expire),
    .phase  (phase)
  );

  always_comb begin
    state_d   = state_q;
    msg_d     = msg_q;
    owner_d   = owner_q;
    gap_cnt_d = gap_cnt_q;
    ready     = '0;
    load      = 1'b0;
    take      = 1'b0;
    case (state_q)
      ST_IDLE: take = any_req;
      ST_SHOW: begin
        // Expiry wins: nothing is accepted on the last SHOW cycle, not even a preempt.
        if (expire) begin
          state_d   = HAS_GAP ? ST_GAP : ST_IDLE;
          gap_cnt_d = '0;
        end else begin
          take = any_req && (pick < owner_q);
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) state_d = ST_IDLE;
        else                       gap_cnt_d = gap_cnt_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    if (take) begin
      state_d = ST_SHOW;
      load    = 1'b1;
      owner_d = pick;
      ready   = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick;
      msg_d   = '{value: req_value_arr[pick], en: req_en_arr[pick], blink: bus.req_blink[pick]};
    end
  end

  // Display registers are loaded from the next state so content lags accept by one cycle.
  always_comb begin
    seg_value_d = bus.base_value;
    seg_en_d    = bus.base_en;
    grant_d     = GRANT_NONE;
    busy_d      = 1'b0;
    case (state_d)
      ST_SHOW: begin
        seg_value_d = msg_d.value;
        seg_en_d    = msg_d.blink ? (msg_d.en & {8{phase}}) : msg_d.en;
        grant_d     = owner_d;
        busy_d      = 1'b1;
      end
      ST_GAP: begin
        seg_value_d = msg_d.value;
        seg_en_d    = '0;
        busy_d      = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      msg_q       <= '0;
      owner_q     <= GRANT_NONE;
      gap_cnt_q   <= '0;
      seg_value_q <= '0;
      seg_en_q    <= '0;
      grant_q     <= GRANT_NONE;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      msg_q       <= msg_d;
      owner_q     <= owner_d;
      gap_cnt_q   <= gap_cnt_d;
      seg_value_q <= seg_value_d;
      seg_en_q    <= seg_en_d;
      grant_q     <= grant_d;
      busy_q      <= busy_d;
    end
  end

  // The accept pulse is combinational, so it is masked while reset is held.
  assign bus.req_ready = ready & {NUM_REQ{rst_n}};
  assign bus.seg_value = seg_value_q;
  assign bus.seg_en    = seg_en_q;
  assign bus.grant     = grant_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_seg_arbiter.sv
// Self-checking bench for seg_arbiter: directed scenarios plus random traffic, all
// compared against a message-level reference model (remaining time, message age).
module tb_seg_arbiter;

  localparam int HOLD  = 10;
  localparam int BLINK = 3;
  localparam int GAP   = 2;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  req_valid = '0;
  logic [2:0]  req_blink = '0;
  logic [31:0] r_value [3];
  logic [7:0]  r_en    [3];
  logic [31:0] base_value = '0;
  logic [7:0]  base_en    = '0;

  always #5 clk = ~clk;

  seg_arbiter_if bus_a ();
  seg_arbiter_if bus_b ();

  assign bus_a.base_value = base_value;
  assign bus_a.base_en    = base_en;
  assign bus_a.req_valid  = req_valid;
  assign bus_a.req_value  = {r_value[2], r_value[1], r_value[0]};
  assign bus_a.req_en     = {r_en[2], r_en[1], r_en[0]};
  assign bus_a.req_blink  = req_blink;
  assign bus_b.base_value = base_value;
  assign bus_b.base_en    = base_en;
  assign bus_b.req_valid  = req_valid;
  assign bus_b.req_value  = {r_value[2], r_value[1], r_value[0]};
  assign bus_b.req_en     = {r_en[2], r_en[1], r_en[0]};
  assign bus_b.req_blink  = req_blink;

  seg_arbiter #(.HOLD_CYCLES(HOLD), .BLINK_CYCLES(BLINK), .GAP_CYCLES(GAP)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a)
  );

  seg_arbiter #(.HOLD_CYCLES(HOLD), .BLINK_CYCLES(BLINK), .GAP_CYCLES(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b)
  );

  // Reference model: remaining SHOW cycles, remaining GAP cycles, age of current message.
  int          m_show, m_gap, m_age, m_owner;
  logic [31:0] m_value;
  logic [7:0]  m_en;
  logic        m_blink;
  bit          sel;   // 0 -> dut_a (GAP=2), 1 -> dut_b (GAP=0)
  int          cyc;
  int          checks   = 0;
  int          failures = 0;

  logic [2:0]  exp_ready, obs_ready;
  logic [31:0] exp_value, obs_value;
  logic [7:0]  exp_en, obs_en;
  logic [1:0]  exp_grant, obs_grant;
  logic        exp_busy, obs_busy, val_care;

  function automatic string show();
    return $sformatf("got ready=%b value=%h en=%h grant=%0d busy=%b, want ready=%b value=%h en=%h grant=%0d busy=%b",
                     obs_ready, obs_value, obs_en, obs_grant, obs_busy,
                     exp_ready, exp_value, exp_en, exp_grant, exp_busy);
  endfunction

  function automatic bit differs();
    return (obs_ready !== exp_ready) || (obs_en !== exp_en) || (obs_grant !== exp_grant) ||
           (obs_busy !== exp_busy) || (val_care && (obs_value !== exp_value));
  endfunction

  task automatic model_reset();
    m_show = 0; m_gap = 0; m_age = 0; m_owner = 3;
    m_value = '0; m_en = '0; m_blink = 1'b0;
  endtask

  // One clock: sample ready before the edge, advance the model, sample outputs after it.
  task automatic cycle();
    int         pick;
    logic [1:0] p2;
    #1;
    obs_ready = sel ? bus_b.req_ready : bus_a.req_ready;
    pick = 3;
    for (int i = 2; i >= 0; i--) if (req_valid[i]) pick = i;
    p2 = 2'(pick);
    exp_ready = '0;
    if (pick < 3 && ((m_show == 0 && m_gap == 0) || (m_show > 1 && pick < m_owner)))
      exp_ready = 3'(1 << pick);
    @(posedge clk);
    if (exp_ready != 3'b000) begin
      m_show = HOLD; m_age = 0; m_owner = pick;
      m_value = r_value[p2]; m_en = r_en[p2]; m_blink = req_blink[p2];
    end else if (m_show > 0) begin
      if (m_show == 1) begin m_show = 0; m_gap = sel ? 0 : GAP; end
      else begin m_show--; m_age++; end
    end else if (m_gap > 0) begin
      m_gap--;
    end
    val_care = 1'b1;
    if (m_show > 0) begin
      exp_value = m_value;
      exp_en    = (m_blink && ((m_age / BLINK) % 2 == 1)) ? 8'h00 : m_en;
      exp_grant = 2'(m_owner);
      exp_busy  = 1'b1;
    end else if (m_gap > 0) begin
      exp_value = '0; val_care = 1'b0;
      exp_en = 8'h00; exp_grant = 2'd3; exp_busy = 1'b1;
    end else begin
      exp_value = base_value; exp_en = base_en; exp_grant = 2'd3; exp_busy = 1'b0;
    end
    #1;
    obs_value = sel ? bus_b.seg_value : bus_a.seg_value;
    obs_en    = sel ? bus_b.seg_en    : bus_a.seg_en;
    obs_grant = sel ? bus_b.grant     : bus_a.grant;
    obs_busy  = sel ? bus_b.busy      : bus_a.busy;
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    req_valid = '0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    req_valid = 3'b111;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus_a.seg_value, bus_a.seg_en, bus_a.grant, bus_a.busy, bus_a.req_ready} !== {32'h0, 8'h00, 2'd3, 1'b0, 3'b000}) begin
      failures++;
      $display("FAIL reset_a: got value=%h en=%h grant=%0d busy=%b ready=%b, want 0/00/3/0/000",
               bus_a.seg_value, bus_a.seg_en, bus_a.grant, bus_a.busy, bus_a.req_ready);
    end
    checks++;
    if ({bus_b.seg_value, bus_b.seg_en, bus_b.grant, bus_b.busy, bus_b.req_ready} !== {32'h0, 8'h00, 2'd3, 1'b0, 3'b000}) begin
      failures++;
      $display("FAIL reset_b: got value=%h en=%h grant=%0d busy=%b ready=%b, want 0/00/3/0/000",
               bus_b.seg_value, bus_b.seg_en, bus_b.grant, bus_b.busy, bus_b.req_ready);
    end
    req_valid = '0;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_idle_base();
    base_value = 32'hAAA0_0000;
    base_en    = 8'hE0;
    for (int c = 0; c < 3; c++) begin
      cycle();
      checks++;
      if (differs() || obs_value !== 32'hAAA0_0000 || obs_en !== 8'hE0 || obs_grant !== 2'd3) begin
        failures++; $display("FAIL idle_base cycle %0d: %s", c, show());
      end
    end
  endtask

  task automatic test_priority();
    int acc2 = -1;
    do_reset();
    for (int i = 0; i < 3; i++) begin r_value[i] = $urandom; r_en[i] = 8'($urandom); end
    req_blink = '0;
    req_valid = 3'b110;
    for (int c = 0; c < 18; c++) begin
      cycle();
      checks++;
      if (differs()) begin failures++; $display("FAIL priority cycle %0d: %s", c, show()); end
      if (c == 0) begin
        checks++;
        if (obs_ready !== 3'b010 || obs_grant !== 2'd1) begin
          failures++; $display("FAIL priority_first: got ready=%b grant=%0d, want 010/1", obs_ready, obs_grant);
        end
      end
      if (obs_ready[1]) req_valid[1] = 1'b0;
      if (obs_ready[2]) begin req_valid[2] = 1'b0; if (acc2 < 0) acc2 = c; end
    end
    checks++;
    if (acc2 != 13) begin failures++; $display("FAIL priority_req2_accept: got cycle %0d, want 13", acc2); end
  endtask

  task automatic test_preempt();
    int grant0 = 0;
    do_reset();
    for (int i = 0; i < 3; i++) begin r_value[i] = $urandom; r_en[i] = 8'($urandom); end
    req_valid = 3'b100;
    for (int c = 0; c < 20; c++) begin
      cycle();
      checks++;
      if (differs()) begin failures++; $display("FAIL preempt cycle %0d: %s", c, show()); end
      if (obs_grant === 2'd0) grant0++;
      if (c == 4) begin
        checks++;
        if (obs_ready !== 3'b001 || obs_grant !== 2'd0 || obs_busy !== 1'b1) begin
          failures++; $display("FAIL preempt_take: got ready=%b grant=%0d busy=%b, want 001/0/1", obs_ready, obs_grant, obs_busy);
        end
      end
      if (c == 0) req_valid = 3'b000;
      if (c == 3) req_valid = 3'b001;
      if (c == 4) req_valid = 3'b000;
    end
    checks++;
    if (grant0 != 10) begin failures++; $display("FAIL preempt_hold: got %0d owner-0 cycles, want 10", grant0); end
  endtask

  task automatic test_blink();
    logic [7:0] pat [10];
    pat = '{8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h00};
    do_reset();
    r_value[1] = $urandom; r_en[1] = 8'hFF; req_blink = 3'b010;
    req_valid = 3'b010;
    for (int c = 0; c < 12; c++) begin
      cycle();
      req_valid = 3'b000;
      checks++;
      if (differs()) begin failures++; $display("FAIL blink cycle %0d: %s", c, show()); end
      if (c < 10) begin
        checks++;
        if (obs_en !== pat[c]) begin failures++; $display("FAIL blink_pattern cycle %0d: got en=%h, want %h", c, obs_en, pat[c]); end
      end
    end
    req_blink = '0;
  endtask

  task automatic test_reset_mid_show();
    do_reset();
    r_value[0] = $urandom; r_en[0] = 8'($urandom) | 8'h01;
    req_valid = 3'b001;
    for (int c = 0; c < 6; c++) begin
      cycle();
      req_valid = 3'b000;
      checks++;
      if (differs()) begin failures++; $display("FAIL mid_show cycle %0d: %s", c, show()); end
    end
    req_valid = 3'b111;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus_a.seg_value, bus_a.seg_en, bus_a.grant, bus_a.busy, bus_a.req_ready} !== {32'h0, 8'h00, 2'd3, 1'b0, 3'b000}) begin
      failures++;
      $display("FAIL mid_show_abort: got value=%h en=%h grant=%0d busy=%b ready=%b, want 0/00/3/0/000",
               bus_a.seg_value, bus_a.seg_en, bus_a.grant, bus_a.busy, bus_a.req_ready);
    end
    @(negedge clk);
    req_valid = 3'b000;
    base_value = 32'h1234_5678; base_en = 8'h3C;
    rst_n = 1'b1;
    model_reset();
    cycle();
    checks++;
    if (differs() || obs_value !== 32'h1234_5678 || obs_en !== 8'h3C) begin
      failures++; $display("FAIL mid_show_release: %s", show());
    end
  endtask

  task automatic test_gap0();
    int accepts = 0;
    sel = 1'b1;
    do_reset();
    r_value[1] = $urandom; r_en[1] = 8'($urandom);
    req_valid = 3'b010;
    for (int c = 0; c < 23; c++) begin
      cycle();
      checks++;
      if (differs()) begin failures++; $display("FAIL gap0 cycle %0d: %s", c, show()); end
      if (obs_ready === 3'b010) accepts++;
    end
    checks++;
    if (accepts != 3) begin failures++; $display("FAIL gap0_accepts: got %0d, want 3", accepts); end
    sel = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      cycle();
      checks++;
      if (differs()) begin failures++; $display("FAIL random cycle %0d: %s", c, show()); end
      for (int i = 0; i < 3; i++) begin
        if (req_valid[i]) begin
          if ($urandom_range(7) == 0 || (obs_ready[i] && $urandom_range(1) == 0)) req_valid[i] = 1'b0;
        end else if ($urandom_range(9) == 0) begin
          req_valid[i] = 1'b1;
          r_value[i]   = $urandom;
          r_en[i]      = 8'($urandom);
          req_blink[i] = 1'($urandom);
        end
      end
      if ($urandom_range(15) == 0) begin base_value = $urandom; base_en = 8'($urandom); end
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin r_value[i] = '0; r_en[i] = '0; end
    sel = 1'b0;
    cyc = 0;
    model_reset();
    test_reset();
    test_idle_base();
    test_priority();
    test_preempt();
    test_blink();
    test_reset_mid_show();
    test_gap0();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg_arbiter.md
SEG_ARBITER -- requirements
Module: seg_arbiter

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 50_000_000, meaning cycles one accepted message is shown (1 s at 50 MHz).
REQ-002 SHALL have parameter BLINK_CYCLES, default 12_500_000, meaning half-period of the blink toggle.
REQ-003 SHALL have parameter GAP_CYCLES, default 2, meaning blank cycles between two consecutive messages (0 allowed).
REQ-004 SHALL have port clk, input, 1, meaning the single system clock.
REQ-005 SHALL have port rst_n, input, 1, meaning the reset, which is asynchronous and active-low.
REQ-006 SHALL have ports base_value (input, 32) and base_en (input, 8), meaning the default display content (state indication) shown when no message is active.
REQ-007 SHALL have ports req_valid (input, 3), req_value (input, 3x32 packed, requester i at bits [32i+31:32i]), req_en (input, 3x8 packed), and req_blink (input, 3), meaning three message requesters, where index 0 has the highest priority.
REQ-008 SHALL have port req_ready, output, 3, meaning one-hot accept pulse for the cycle a request is taken.
REQ-009 SHALL have ports seg_value (output, 32) and seg_en (output, 8), meaning the registered content that feeds hex_display data/enable.
REQ-010 SHALL have ports grant (output, 2, value 3 means none) and busy (output, 1), meaning the current owner and that a message or gap is active.

Function
REQ-011 SHALL implement FSM states IDLE, SHOW, GAP.
REQ-012 In IDLE, the next-cycle seg_value/seg_en SHALL equal base_value/base_en, grant=3, busy=0.
REQ-013 In IDLE, when any req_valid is high, the block SHALL accept the lowest index, pulse req_ready[i] for exactly that cycle, latch value/en/blink, load the hold counter, and go to SHOW.
REQ-014 Accepted content SHALL appear on seg_value/seg_en the cycle after req_ready (1-cycle latency).
REQ-015 In SHOW, seg_value SHALL be the latched value; seg_en SHALL be the latched en, ANDed with the blink phase when the latched blink bit is 1.
REQ-016 The blink phase SHALL start at 1 on accept and toggle every BLINK_CYCLES cycles; a free-running phase is not allowed.
REQ-017 SHOW SHALL last exactly HOLD_CYCLES cycles, then move to GAP (GAP_CYCLES>0) or IDLE (GAP_CYCLES=0).
REQ-018 In SHOW, a valid request with index strictly lower than the grant SHALL preempt: accept it, reload the counter, reset the blink phase, and stay in SHOW without a gap.
REQ-019 Equal- or lower-priority requests SHALL wait; req_ready stays 0 and the request is not lost while valid remains high.
REQ-020 In GAP, seg_en SHALL be 8'h00 and grant=3 for GAP_CYCLES cycles, then IDLE; requests are not accepted in GAP.
REQ-021 A request present on the hold-expiry cycle SHALL NOT be accepted that cycle; with GAP_CYCLES=0 it is accepted on the IDLE cycle that follows.
REQ-022 Simultaneous req_valid SHALL resolve by fixed priority, with at most one req_ready bit high.
REQ-023 The counters SHALL be sized $clog2(max(parameter)+1) and SHALL NOT wrap; count reaching terminal value is the only expiry condition.
REQ-024 A requester dropping req_valid after acceptance SHALL NOT affect the message being shown.

Reset
REQ-025 While rst_n=0: state=IDLE, seg_value=0, seg_en=8'h00, grant=3, busy=0, req_ready=0, counters=0, and the blink phase=1.
REQ-026 Reset asserted mid-SHOW SHALL abort the message immediately (asynchronously); the first cycle after release SHALL show base content.

Structure
REQ-027 The state encodings and the GRANT_NONE constant SHALL live in a shared include alongside st_state.v/system_para.v.
REQ-028 The hold/blink timer SHALL be one sub-module seg_hold_timer (load, count, expire, and phase outputs) instantiated once.

Verification (HOLD=10, BLINK=3, GAP=2)
REQ-029 Idle with base_value=32'hAAA0_0000 and base_en=8'hE0 -> outputs equal base the next cycle, grant=3.
REQ-030 req_valid=3'b110 in the same cycle -> req_ready=3'b010, grant=1, and req1 content shown 10 cycles, then 2 blank cycles, then req2 accepted.
REQ-031 req2 showing and req0 asserted at cycle 4 -> immediate preempt, req0 shown 10 full cycles, no gap.
REQ-032 req_blink=1 with en=8'hFF -> seg_en follows FF,FF,FF,00,00,00,FF... from the accept.
REQ-033 rst_n pulsed low at SHOW cycle 5 -> outputs 0 during reset, base content after release, and req_ready=0.
REQ-034 GAP_CYCLES=0 with a request held through expiry -> one IDLE cycle showing base, then re-accept.
